dtc_frame_io: RTL

- Byte-stream front end and result collector for one combinational decision-tree classifier (12-bit feature vector in, 3-bit class out).
- Assembles two-byte frames into a 12-bit feature vector and drives it onto the classifier inputs.
- Waits a programmable settle time, samples the class label, and queues the tagged result in a small FIFO with valid/ready output.
- Sits between the host byte link and any dtc_* classifier instance; the classifier itself stays purely combinational.

---
 rtl/dtc_frame_io.sv | 94 +++++++++
 1 files changed

// File: rtl/dtc_frame_io.sv
// dtc_frame_io: assembles two-byte frames into a 12-bit feature vector for a combinational
// decision-tree classifier and queues the tagged, settled class label in a valid/ready FIFO.
module dtc_frame_io #(
  parameter int SETTLE_CYC = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic [11:0]      feat_o,
  input  logic [2:0]       class_i,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [2:0]       m_class,
  output logic [TAG_W-1:0] m_tag,
  output logic             m_err,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {B0, B1, SETTLE, CAP} state_t;
  state_t st;
  logic en, err_r, s_fire, push, pop;
  logic [3:0] cnt;
  logic [TAG_W-1:0] tag;
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [2:0] mem_class [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_err;
  // a free slot is reserved only when a frame starts, so the CAP push can never overflow
  assign s_ready = en && ((st == B0 && count < (AW+1)'(FIFO_DEPTH)) || st == B1);
  assign s_fire = s_valid && s_ready;
  assign push = st == CAP;
  assign pop = m_valid && m_ready;
  assign m_valid = count != '0;
  assign m_class = mem_class[rp];
  assign m_tag = mem_tag[rp];
  assign m_err = mem_err[rp];
  assign busy = st != B0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= B0;
      en <= 1'b0;
      feat_o <= '0;
      err_r <= 1'b0;
      cnt <= '0;
      tag <= '0;
    end else begin
      en <= 1'b1;
      case (st)
        B0: if (s_fire) begin
          feat_o[7:0] <= s_data;
          st <= B1;
        end
        B1: if (s_fire) begin
          feat_o[11:8] <= s_data[3:0];
          err_r <= |s_data[7:4];
          cnt <= 4'(SETTLE_CYC - 1);
          st <= SETTLE;
        end
        SETTLE: if (cnt == '0) st <= CAP; else cnt <= cnt - 1'b1;
        CAP: begin
          tag <= tag + 1'b1;
          st <= B0;
        end
        default: st <= B0;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      mem_err <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_class[i] <= '0;
        mem_tag[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_class[wp] <= class_i;
        mem_tag[wp] <= tag;
        mem_err[wp] <= err_r;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule
